// File: rtl/mem_access_unit_if.sv
// CPU-request and data-memory signal bundle for mem_access_unit.
// The slave modport is the unit itself; master is the CPU/memory side.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_BITS = 12
);
  logic                 Valid;
  logic                 Ready;
  logic                 Store;
  logic [1:0]           Size;
  logic                 SignExt;
  logic [31:0]          Addr;
  logic [31:0]          WData;
  logic [31:0]          PC;
  logic                 Done;
  logic [31:0]          RData;
  logic                 Exc;
  logic                 MReq;
  logic                 MWE;
  logic [ADDR_BITS-1:0] MAddr;
  logic [31:0]          MWD;
  logic [31:0]          MRD;
  logic                 MAck;

  modport slave (
    input  Valid, Store, Size, SignExt, Addr, WData, PC, MRD, MAck,
    output Ready, Done, RData, Exc, MReq, MWE, MAddr, MWD
  );

  modport master (
    output Valid, Store, Size, SignExt, Addr, WData, PC, MRD, MAck,
    input  Ready, Done, RData, Exc, MReq, MWE, MAddr, MWD
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator on a word-only memory: lane select/extend on loads, RMW for sub-word stores.
// Define MEM_TRACE_EN to print one line per completed memory write.
module mem_access_unit #(
  parameter int unsigned ADDR_BITS  = 12,
  parameter int unsigned WORD_LIMIT = 3072
) (
  input logic              CLK,
  input logic              Reset,
  mem_access_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StResp} state_e;

  function automatic logic [31:0] extract(logic [31:0] w, logic [1:0] sz, logic [1:0] off,
                                          logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] w, logic [1:0] sz, logic [1:0] off,
                                        logic [31:0] wd);
    logic [31:0] r;
    r = w;
    case (sz)
      2'b00: r[{off, 3'b000} +: 8] = wd[7:0];
      2'b01: begin
        if (off[1]) r[31:16] = wd[15:0];
        else        r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        signext_q, signext_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;
  logic        mreq_q, mreq_d;
  logic        mwe_q, mwe_d;
  logic [31:0] mwd_q, mwd_d;
  logic        done_q, done_d;
  logic        exc_q, exc_d;
  logic [31:0] rdata_q, rdata_d;

  logic        misaligned, out_of_range, fault, ack;
  logic [31:0] word_idx;

  assign word_idx     = 32'(bus.Addr[ADDR_BITS+1:2]);
  assign misaligned   = ((bus.Size == 2'b01) && bus.Addr[0]) ||
                        (bus.Size[1] && (bus.Addr[1:0] != 2'b00));
  assign out_of_range = (bus.Addr[31:ADDR_BITS+2] != '0) || (word_idx >= WORD_LIMIT);
  assign fault        = misaligned || out_of_range;
  // An acknowledge only counts against a request that is actually on the bus.
  assign ack          = mreq_q && bus.MAck;

  always_comb begin
    state_d   = state_q;
    store_d   = store_q;
    size_d    = size_q;
    signext_d = signext_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    pc_d      = pc_q;
    mwd_d     = mwd_q;
    rdata_d   = rdata_q;
    done_d    = 1'b0;
    exc_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.Valid) begin
          store_d   = bus.Store;
          size_d    = bus.Size;
          signext_d = bus.SignExt;
          addr_d    = bus.Addr;
          wdata_d   = bus.WData;
          pc_d      = bus.PC;
          if (fault) begin
            state_d = StResp;
            done_d  = 1'b1;
            exc_d   = 1'b1;
            rdata_d = '0;
          end else if (bus.Store && bus.Size[1]) begin
            state_d = StWr;
            mwd_d   = bus.WData;
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (ack) begin
          if (store_q) begin
            state_d = StWr;
            mwd_d   = merge(bus.MRD, size_q, addr_q[1:0], wdata_q);
          end else begin
            state_d = StResp;
            done_d  = 1'b1;
            rdata_d = extract(bus.MRD, size_q, addr_q[1:0], signext_q);
          end
        end
      end
      StWr: begin
        if (ack) begin
          state_d = StResp;
          done_d  = 1'b1;
          rdata_d = '0;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // The request lags state entry by one cycle, which yields the one-cycle gap inside an RMW.
    mreq_d = ((state_q == StRd) || (state_q == StWr)) && (state_d == state_q);
    mwe_d  = mreq_d && (state_q == StWr);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      store_q   <= 1'b0;
      size_q    <= 2'b00;
      signext_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      pc_q      <= '0;
      mreq_q    <= 1'b0;
      mwe_q     <= 1'b0;
      mwd_q     <= '0;
      done_q    <= 1'b0;
      exc_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      store_q   <= store_d;
      size_q    <= size_d;
      signext_q <= signext_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      pc_q      <= pc_d;
      mreq_q    <= mreq_d;
      mwe_q     <= mwe_d;
      mwd_q     <= mwd_d;
      done_q    <= done_d;
      exc_q     <= exc_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.Ready = (state_q == StIdle);
  assign bus.Done  = done_q;
  assign bus.Exc   = exc_q;
  assign bus.RData = rdata_q;
  assign bus.MReq  = mreq_q;
  assign bus.MWE   = mwe_q;
  assign bus.MAddr = addr_q[ADDR_BITS+1:2];
  assign bus.MWD   = mwd_q;

  logic unused_addr;
  assign unused_addr = ^addr_q[31:ADDR_BITS+2];

`ifdef MEM_TRACE_EN
  always_ff @(posedge CLK) begin
    if ((state_q == StWr) && ack) begin
      $display("%0t@%08h: *%08h <= %08h", $time, pc_q,
               {{(30 - ADDR_BITS){1'b0}}, addr_q[ADDR_BITS+1:2], 2'b00}, mwd_q);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_q;
`endif

endmodule
